// File: rtl/r29_int4_pkg.sv
// r29_int4_pkg
//   Shared definitions for the r29_int4 PE read-side decoder.
//   - Counter slot geometry (29 slots: 15 add, 14 sub).
//   - Decoder FSM state encoding.
//   - sq_weight(idx): squared encoded magnitude for a slot (9-bit, 4..256).
//   - slot_sign(idx): 1 when the slot is subtracted, 0 when it is added.
package r29_int4_pkg;

  localparam int ADD_CNT = 15;
  localparam int SUB_CNT = 14;
  localparam int NUM_CNT = ADD_CNT + SUB_CNT;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Add slots encode magnitude idx+2 (2..16), sub slots encode idx-13 (2..15).
  function automatic logic [8:0] sq_weight(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] m;
    logic [8:0]       m9;
    if (idx < IDX_W'(ADD_CNT)) begin
      m = idx + 5'd2;
    end else begin
      m = idx - 5'd13;
    end
    m9 = {4'd0, m};
    return m9 * m9;
  endfunction

  function automatic logic slot_sign(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(ADD_CNT));
  endfunction

endpackage

// File: rtl/r29_mac_step.sv
// r29_mac_step
//   One decode step, purely combinational: sum = acc +/- cnt*weight,
//   wrapped to ACC_W bits, with signed-overflow detection.
// Ports
//   acc      in   ACC_W      current accumulator (two's complement)
//   cnt      in   REG_SIZE   unsigned counter value
//   weight   in   9          unsigned squared magnitude
//   subtract in   1          1 = subtract the product, 0 = add it
//   sum      out  ACC_W      wrapped result
//   wrap     out  1          signed overflow occurred on this step
module r29_mac_step #(
  parameter int REG_SIZE = 16,
  parameter int ACC_W    = 32
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [REG_SIZE-1:0] cnt,
  input  logic [8:0]          weight,
  input  logic                subtract,
  output logic [ACC_W-1:0]    sum,
  output logic                wrap
);

  localparam int PROD_W = REG_SIZE + 9;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    acc_x;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    sum_x;

  assign prod = {9'd0, cnt} * {{REG_SIZE{1'b0}}, weight};

  // One guard bit above ACC_W: both operands fit in ACC_W+1 signed bits, so
  // the extended sum is exact and disagreement of its top two bits is the wrap.
  // The product's MSB is always 0 (weight <= 256), so sign extension is safe.
  assign acc_x  = {acc[ACC_W-1], acc};
  assign prod_x = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_x  = subtract ? (acc_x - prod_x) : (acc_x + prod_x);

  assign sum  = sum_x[ACC_W-1:0];
  assign wrap = sum_x[ACC_W] ^ sum_x[ACC_W-1];

endmodule

// File: rtl/r29_int4_decoder.sv
// r29_int4_decoder
//   Snapshots the 29 PE histogram counters, then decodes them serially into
//   S = sum_k w_k*(cnt_add[k] - cnt_sub[k]) using one time-shared multiplier.
// Ports
//   clk                 in   1              clock, posedge
//   rst                 in   1              asynchronous reset, active low
//   start_in            in   1              begin a decode (IDLE only)
//   counter_in          in   REG_SIZE*29    PE counters, slot i at [i*REG_SIZE +: REG_SIZE]
//   fsm_out_select_out  out  1              high in ACC/DONE (PE zeroes its bus)
//   busy_out            out  1              high in SNAP/ACC/DONE
//   result_out          out  ACC_W          signed S, valid with result_valid_out
//   result_valid_out    out  1              result handshake valid
//   result_ready_in     in   1              result handshake ready
//   overflow_out        out  1              sticky per run: S wrapped
module r29_int4_decoder
  import r29_int4_pkg::*;
#(
  parameter int REG_SIZE = 16,
  parameter int ACC_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_in,
  input  logic [REG_SIZE*NUM_CNT-1:0]  counter_in,
  output logic                         fsm_out_select_out,
  output logic                         busy_out,
  output logic [ACC_W-1:0]             result_out,
  output logic                         result_valid_out,
  input  logic                         result_ready_in,
  output logic                         overflow_out
);

  state_t                                 state_reg;
  state_t                                 state_next;
  logic [NUM_CNT-1:0][REG_SIZE-1:0]       snap_reg;
  logic [IDX_W-1:0]                       idx_reg;
  logic [ACC_W-1:0]                       acc_reg;
  logic [ACC_W-1:0]                       result_reg;
  logic                                   valid_reg;
  logic                                   ovf_reg;

  logic [ACC_W-1:0]                       mac_sum;
  logic                                   mac_wrap;

  r29_mac_step #(
    .REG_SIZE (REG_SIZE),
    .ACC_W    (ACC_W)
  ) u_mac (
    .acc      (acc_reg),
    .cnt      (snap_reg[idx_reg]),
    .weight   (sq_weight(idx_reg)),
    .subtract (slot_sign(idx_reg)),
    .sum      (mac_sum),
    .wrap     (mac_wrap)
  );

  // Next state and state-decoded outputs. Nothing here depends on start_in or
  // result_ready_in except the next state, so outputs stay registered-only.
  always_comb begin
    state_next         = state_reg;
    fsm_out_select_out = 1'b0;
    busy_out           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in) state_next = SNAP;
      end
      SNAP: begin
        busy_out   = 1'b1;
        state_next = ACC;
      end
      ACC: begin
        busy_out           = 1'b1;
        fsm_out_select_out = 1'b1;
        if (idx_reg == IDX_W'(NUM_CNT - 1)) state_next = DONE;
      end
      DONE: begin
        busy_out           = 1'b1;
        fsm_out_select_out = 1'b1;
        if (valid_reg && result_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      snap_reg   <= '0;
      idx_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        SNAP: begin
          snap_reg <= counter_in;
          acc_reg  <= '0;
          idx_reg  <= '0;
          ovf_reg  <= 1'b0;
        end
        ACC: begin
          acc_reg <= mac_sum;
          idx_reg <= idx_reg + 5'd1;
          if (mac_wrap) ovf_reg <= 1'b1;
        end
        DONE: begin
          // First DONE cycle loads the output register; valid then holds
          // until the handshake completes.
          if (!valid_reg) begin
            valid_reg  <= 1'b1;
            result_reg <= acc_reg;
          end else if (result_ready_in) begin
            valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_out       = result_reg;
  assign result_valid_out = valid_reg;
  assign overflow_out     = ovf_reg;

endmodule
